// File: rtl/gpu_pkg.sv
// Shared GPU framebuffer types and geometry constants.
// Region size is the VGA frame split evenly across the PPU cores.
package gpu_pkg;

  localparam int VGA_WIDTH       = 800;
  localparam int VGA_HEIGHT      = 600;
  localparam int GPU_CORES_COUNT = 10;
  localparam int FB_REGION_SIZE  = (VGA_WIDTH * VGA_HEIGHT) / GPU_CORES_COUNT;

  typedef enum logic [2:0] {
    START,
    RENDER,
    WAIT_SWAP,
    SWAP,
    CLEAR
  } fb_state_t;

endpackage

// File: rtl/fb_clear_sweep.sv
// Back-bank clear sweep: after a go pulse, writes addresses 0..REGION_SIZE-1 on consecutive cycles.
// done is high in the cycle carrying the last address, so the caller can leave on that edge.
module fb_clear_sweep #(
  parameter int ADDR_W      = 32,
  parameter int REGION_SIZE = 48000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(REGION_SIZE - 1);

  assign done = clr_we && (clr_addr == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_we   <= 1'b0;
      clr_addr <= '0;
    end else if (go) begin
      clr_we   <= 1'b1;
      clr_addr <= '0;
    end else if (clr_we) begin
      if (done) begin
        clr_we   <= 1'b0;
        clr_addr <= '0;
      end else begin
        clr_addr <= clr_addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/fb_swap_ctrl.sv
// Double-buffer scheduler: gathers per-core done, swaps banks on frame_end, restarts rendering.
// FB_CLEAR_EN adds a back-bank clear sweep between the swap and the next render_start.
module fb_swap_ctrl import gpu_pkg::*; #(
  parameter int CORES_COUNT   = GPU_CORES_COUNT,
  parameter int BUFFER_ADDR_W = 32,
  parameter int COLOR_WIDTH   = 16,
  parameter int REGION_SIZE   = FB_REGION_SIZE,
  parameter int CLEAR_COLOR   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CORES_COUNT-1:0]   core_done,
  input  logic                     frame_end,
  output logic                     front_sel,
  output logic                     back_sel,
  output logic                     render_start,
  output logic                     clr_we,
  output logic [BUFFER_ADDR_W-1:0] clr_addr,
  output logic [COLOR_WIDTH-1:0]   clr_wdata,
  output logic [15:0]              repeat_count,
  output logic [15:0]              frame_count
);

  if (REGION_SIZE < 1 || $clog2(REGION_SIZE) > BUFFER_ADDR_W) begin : g_bad_region
    $error("fb_swap_ctrl: REGION_SIZE does not fit BUFFER_ADDR_W");
  end
  if ((CLEAR_COLOR >> COLOR_WIDTH) != 0) begin : g_bad_color
    $error("fb_swap_ctrl: CLEAR_COLOR does not fit COLOR_WIDTH");
  end

  fb_state_t              state, state_nxt;
  logic [CORES_COUNT-1:0] done_mask, done_mask_nxt;
  logic                   swap, rep_inc, sweep_go, sweep_done;

  assign back_sel = ~front_sel;

`ifdef FB_CLEAR_EN
  fb_clear_sweep #(
    .ADDR_W      (BUFFER_ADDR_W),
    .REGION_SIZE (REGION_SIZE)
  ) u_clear_sweep (
    .clk      (clk),
    .rst      (rst),
    .go       (sweep_go),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .done     (sweep_done)
  );
  assign clr_wdata = COLOR_WIDTH'(CLEAR_COLOR);
`else
  assign sweep_done = 1'b0;
  assign clr_we     = 1'b0;
  assign clr_addr   = '0;
  assign clr_wdata  = '0;
`endif

  always_comb begin
    state_nxt     = state;
    done_mask_nxt = done_mask;
    swap          = 1'b0;
    rep_inc       = 1'b0;
    sweep_go      = 1'b0;
    case (state)
      // After reset START lingers one cycle so the pulse still lands in START.
      START: begin
        done_mask_nxt = '0;
        rep_inc       = frame_end;
        if (render_start) state_nxt = RENDER;
      end
      RENDER: begin
        done_mask_nxt = done_mask | core_done;
        if (&(done_mask | core_done)) begin
          if (frame_end) begin
            state_nxt = SWAP;
            swap      = 1'b1;
          end else begin
            state_nxt = WAIT_SWAP;
          end
        end else begin
          rep_inc = frame_end;
        end
      end
      WAIT_SWAP: begin
        if (frame_end) begin
          state_nxt = SWAP;
          swap      = 1'b1;
        end
      end
      SWAP: begin
        rep_inc = frame_end;
`ifdef FB_CLEAR_EN
        sweep_go  = 1'b1;
        state_nxt = CLEAR;
`else
        state_nxt = START;
`endif
      end
`ifdef FB_CLEAR_EN
      CLEAR: begin
        rep_inc = frame_end;
        if (sweep_done) state_nxt = START;
      end
`endif
      default: state_nxt = START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= START;
      done_mask    <= '0;
      render_start <= 1'b0;
      front_sel    <= 1'b0;
      frame_count  <= 16'd0;
      repeat_count <= 16'd0;
    end else begin
      state        <= state_nxt;
      done_mask    <= done_mask_nxt;
      render_start <= (state_nxt == START);
      if (swap) begin
        front_sel   <= ~front_sel;
        frame_count <= frame_count + 16'd1;
      end
      if (rep_inc && repeat_count != 16'hFFFF) repeat_count <= repeat_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Directed bench for fb_swap_ctrl with 4 cores and an 8-pixel region.
// Works with and without FB_CLEAR_EN.
module tb_fb_swap_ctrl;

  localparam int CORES = 4;
  localparam int RSIZE = 8;
  localparam int AW    = 32;
  localparam int CW    = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [CORES-1:0] core_done = '0;
  logic             frame_end = 1'b0;
  logic             front_sel, back_sel, render_start, clr_we;
  logic [AW-1:0]    clr_addr;
  logic [CW-1:0]    clr_wdata;
  logic [15:0]      repeat_count, frame_count;

  int n_checks = 0;
  int n_fail   = 0;

  fb_swap_ctrl #(
    .CORES_COUNT   (CORES),
    .BUFFER_ADDR_W (AW),
    .COLOR_WIDTH   (CW),
    .REGION_SIZE   (RSIZE),
    .CLEAR_COLOR   (0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .core_done    (core_done),
    .frame_end    (frame_end),
    .front_sel    (front_sel),
    .back_sel     (back_sel),
    .render_start (render_start),
    .clr_we       (clr_we),
    .clr_addr     (clr_addr),
    .clr_wdata    (clr_wdata),
    .repeat_count (repeat_count),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the SWAP cycle; walks through the optional clear and START into RENDER.
  task automatic finish_swap(input string tag);
`ifdef FB_CLEAR_EN
    tick();
    for (int i = 0; i < RSIZE; i++) begin
      check_eq({tag, "_clr_we"}, 32'(clr_we), 32'd1);
      check_eq({tag, "_clr_addr"}, clr_addr, 32'(i));
      check_eq({tag, "_rs_in_clear"}, 32'(render_start), 32'd0);
      tick();
    end
    check_eq({tag, "_clr_we_off"}, 32'(clr_we), 32'd0);
`else
    tick();
`endif
    check_eq({tag, "_rs_on"}, 32'(render_start), 32'd1);
    check_eq({tag, "_clr_wdata"}, 32'(clr_wdata), 32'd0);
    tick();
    check_eq({tag, "_rs_off"}, 32'(render_start), 32'd0);
  endtask

  initial begin
    // Reset state and release
    repeat (3) tick();
    check_eq("rst_front", 32'(front_sel), 32'd0);
    check_eq("rst_back", 32'(back_sel), 32'd1);
    check_eq("rst_rs", 32'(render_start), 32'd0);
    check_eq("rst_clr_we", 32'(clr_we), 32'd0);
    check_eq("rst_clr_addr", clr_addr, 32'd0);
    check_eq("rst_repeat", 32'(repeat_count), 32'd0);
    check_eq("rst_frames", 32'(frame_count), 32'd0);
    rst = 1'b0;
    tick();
    check_eq("rel_rs_on", 32'(render_start), 32'd1);
    tick();
    check_eq("rel_rs_off", 32'(render_start), 32'd0);

    // Cores finish one at a time, then frame_end swaps
    for (int c = 0; c < CORES; c++) begin
      core_done = CORES'(1 << c);
      tick();
    end
    core_done = '0;
    check_eq("t2_no_swap_yet", 32'(front_sel), 32'd0);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    check_eq("t2_front", 32'(front_sel), 32'd1);
    check_eq("t2_back", 32'(back_sel), 32'd0);
    check_eq("t2_frames", 32'(frame_count), 32'd1);
    check_eq("t2_repeat", 32'(repeat_count), 32'd0);
    finish_swap("t2");

    // frame_end with an incomplete mask repeats the frame
    core_done = 4'b0001; tick();
    core_done = 4'b0010; tick();
    core_done = 4'b0100; tick();
    core_done = '0;
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    check_eq("t3_repeat", 32'(repeat_count), 32'd1);
    check_eq("t3_front_hold", 32'(front_sel), 32'd1);
    core_done = 4'b1000; tick();
    core_done = '0;
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    check_eq("t3_front", 32'(front_sel), 32'd0);
    check_eq("t3_frames", 32'(frame_count), 32'd2);
    finish_swap("t3");

    // Last done coincides with frame_end: direct swap, no repeat
    core_done = 4'b0111; tick();
    core_done = 4'b1000;
    frame_end = 1'b1;
    tick();
    core_done = '0;
    frame_end = 1'b0;
    check_eq("t4_front", 32'(front_sel), 32'd1);
    check_eq("t4_frames", 32'(frame_count), 32'd3);
    check_eq("t4_repeat", 32'(repeat_count), 32'd1);
    finish_swap("t4");

`ifdef FB_CLEAR_EN
    // Reset in the middle of the clear sweep
    core_done = 4'b1111;
    frame_end = 1'b1;
    tick();
    core_done = '0;
    frame_end = 1'b0;
    check_eq("t5_frames", 32'(frame_count), 32'd4);
    tick();
    repeat (4) tick();
    check_eq("t5_addr4", clr_addr, 32'd4);
    check_eq("t5_we_mid", 32'(clr_we), 32'd1);
    rst = 1'b1;
    tick();
    check_eq("t5_we_abort", 32'(clr_we), 32'd0);
    check_eq("t5_addr_abort", clr_addr, 32'd0);
`else
    // Reset in the middle of a render pass
    core_done = 4'b0011; tick();
    core_done = '0;
    rst = 1'b1;
    tick();
`endif
    check_eq("t5_front", 32'(front_sel), 32'd0);
    check_eq("t5_frames_rst", 32'(frame_count), 32'd0);
    check_eq("t5_repeat_rst", 32'(repeat_count), 32'd0);
    check_eq("t5_rs_in_rst", 32'(render_start), 32'd0);
    rst = 1'b0;
    tick();
    check_eq("t5_rs_on", 32'(render_start), 32'd1);
    tick();
    check_eq("t5_rs_off", 32'(render_start), 32'd0);

    // Done mask must be empty after reset: cores 2,3 alone do not complete
    core_done = 4'b1100; tick();
    core_done = '0;
    frame_end = 1'b1;
    tick();
    check_eq("t5_mask_cleared_front", 32'(front_sel), 32'd0);
    check_eq("t5_mask_cleared_rep", 32'(repeat_count), 32'd1);

    // Saturation of repeat_count with frame_end held every cycle
    repeat (65533) tick();
    check_eq("t6_repeat_fffe", 32'(repeat_count), 32'hFFFE);
    tick();
    check_eq("t6_repeat_ffff", 32'(repeat_count), 32'hFFFF);
    repeat (3) tick();
    check_eq("t6_repeat_sat", 32'(repeat_count), 32'hFFFF);
    check_eq("t6_frames", 32'(frame_count), 32'd0);
    check_eq("t6_front", 32'(front_sel), 32'd0);
    frame_end = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_swap_ctrl.md
# fb_swap_ctrl

Double-buffer scheduler for the per-core framebuffers. Each core's region holds two banks. The scanout reader fetches pixels from the front bank while the cores render into the back bank. This block collects per-core completion, swaps the banks exactly at a frame boundary, optionally clears the new back bank, and starts the next render pass. It sits in the GPU `clk` domain, beside the scanout reader that feeds the cross-domain FIFO.

## Interface
Parameters:
- `CORES_COUNT`, 10, number of PPU cores / framebuffer regions.
- `BUFFER_ADDR_W`, 32, per-core framebuffer word address width.
- `COLOR_WIDTH`, 16, pixel width.
- `REGION_SIZE`, 48000, pixels per core region (800*600/10).
- `CLEAR_COLOR`, 0, value written by the clear sweep.

Ports:
- `clk`  in  1  GPU clock.
- `rst`  in  1  synchronous, active-high reset.
- `core_done`  in  CORES_COUNT  per-core one-cycle pulse: back-bank render finished.
- `frame_end`  in  1  one-cycle pulse from the scanout reader when it fetches the last pixel of a frame.
- `front_sel`  out  1  bank read by scanout.
- `back_sel`  out  1  bank written by cores; always `~front_sel`.
- `render_start`  out  1  one-cycle pulse, broadcast to all cores.
- `clr_we`  out  1  clear write enable, broadcast to every core's back bank.
- `clr_addr`  out  BUFFER_ADDR_W  clear address.
- `clr_wdata`  out  COLOR_WIDTH  equals `CLEAR_COLOR`.
- `repeat_count`  out  16  saturating count of frames scanned without a swap.
- `frame_count`  out  16  wrapping count of swaps.

## Operation
- FSM states:
  - START: `render_start`=1 for one cycle, done mask cleared, then RENDER.
  - RENDER: OR `core_done` into a sticky mask each cycle. When mask|core_done is all ones, go to WAIT_SWAP.
  - WAIT_SWAP: wait for `frame_end`.
  - SWAP: toggle `front_sel`, increment `frame_count`, then CLEAR (macro on) or START.
  - CLEAR: sweep `clr_addr` 0..REGION_SIZE-1 with `clr_we`=1, then START.
- Same-cycle completion and `frame_end` in RENDER (mask|core_done all ones): go directly to SWAP; no repeat counted.
- `frame_end` in START, RENDER (not completing), SWAP or CLEAR: `repeat_count`+1, saturating at 0xFFFF.
- `core_done` outside RENDER is ignored. Repeated pulses from one core are idempotent.
- `clr_addr` is compared against `REGION_SIZE-1` at full `BUFFER_ADDR_W` width.
- Reset mid-clear or mid-render aborts immediately. The block restarts from START with `front_sel`=0; partially cleared data is not revisited.

## Timing
- All outputs are registered.
- Reset values: `front_sel`=0, `back_sel`=1, `render_start`=0, `clr_we`=0, `clr_addr`=0, `repeat_count`=0, `frame_count`=0; state = START.
- `render_start` is high in the first cycle after `rst` deasserts, and in the first cycle of every START.
- `frame_end` sampled in WAIT_SWAP at cycle t: `front_sel` toggles at t+1, so the first fetch of the next frame reads the new bank.
- Clear sweep: `clr_we` high for exactly REGION_SIZE consecutive cycles, beginning the cycle after the toggle. `render_start` follows in the next cycle.
- Minimum swap-to-render_start: 1 cycle with the macro off, REGION_SIZE+1 cycles with it on.

## Configuration
- `FB_CLEAR_EN` defined:
  - CLEAR state and sweep logic are present.
  - The back bank holds `CLEAR_COLOR` everywhere before `render_start`.
- `FB_CLEAR_EN` undefined:
  - CLEAR is not compiled; SWAP goes to START.
  - `clr_we`, `clr_addr` and `clr_wdata` are tied to 0.
  - Cores are responsible for overwriting every pixel.

## Structure
- Shared package `gpu_pkg`:
  - `fb_state_t` enum (START, RENDER, WAIT_SWAP, SWAP, CLEAR).
  - `REGION_SIZE` derivation from the VGA width, VGA height and `CORES_COUNT` constants.
- One sub-module: `fb_clear_sweep`. It takes `clk`, `rst`, a `go` pulse, and outputs `clr_we`, `clr_addr` and a `done` pulse. It is instantiated only under `FB_CLEAR_EN`.

## Test plan
All scenarios use CORES_COUNT=4, REGION_SIZE=8.
- Reset release: `render_start`=1 for one cycle; `front_sel`=0, `back_sel`=1, both counters 0.
- Cores 0-3 pulse `core_done` in separate cycles, then `frame_end` → `front_sel`=1 one cycle later, `frame_count`=1; with `FB_CLEAR_EN`, `clr_we` high for 8 cycles with addr 0..7, then `render_start`.
- `frame_end` while only cores 0-2 are done → `repeat_count`=1, `front_sel` unchanged. Core 3 done plus a second `frame_end` → swap.
- Core 3's `core_done` and `frame_end` in the same cycle (cores 0-2 already done) → swap at the next cycle, `repeat_count` unchanged.
- `rst` asserted during the clear sweep at addr 4 → `clr_we`=0 next cycle, `front_sel`=0, then `render_start` in the first cycle after release.
- 65536 `frame_end` pulses with no `core_done` → `repeat_count` holds 0xFFFF.
